// File: rtl/bf_pkg.sv
// Shared types and constants for the Brainfuck CPU: opcodes, fetch states, scan direction.
package bf_pkg;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned DEPTH_W_DEF = 8;

    // Opcode encoding shared by the program ROM, fetch unit and executor.
    typedef enum logic [2:0] {
        OpNop  = 3'b000,
        OpOut  = 3'b001,
        OpBack = 3'b010,
        OpIf   = 3'b011,
        OpMovl = 3'b100,
        OpMovr = 3'b101,
        OpDec  = 3'b110,
        OpInc  = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        StFetch    = 2'd0,
        StScanFwd  = 2'd1,
        StScanBack = 2'd2,
        StHalt     = 2'd3
    } fetch_state_t;

    typedef enum logic {
        ScanFwd  = 1'b0,
        ScanBack = 1'b1
    } scan_dir_t;

    // Brackets are resolved inside the fetch unit and never reach the executor.
    function automatic logic is_bracket(input logic [2:0] code);
        return (code == OpIf) || (code == OpBack);
    endfunction

endpackage

// File: rtl/bf_bracket_scan.sv
// Bracket nesting counter: tracks depth during a scan and flags the matching bracket
// or a depth overflow. Direction decides which bracket opens and which closes.
module bf_bracket_scan
    import bf_pkg::*;
#(
    parameter int unsigned DEPTH_W = DEPTH_W_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  scan_dir_t dir,
    input  logic [2:0] code,
    input  logic      load,
    input  logic      step,
    output logic      match,
    output logic      overflow
);

    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;
    logic               opens;
    logic               closes;

    // Classify the current opcode for the scan direction and compute the next depth.
    always_comb begin
        opens    = (dir == ScanFwd) ? (code == OpIf)   : (code == OpBack);
        closes   = (dir == ScanFwd) ? (code == OpBack) : (code == OpIf);
        match    = step && closes && (depth_q == DEPTH_W'(1));
        overflow = step && opens && (&depth_q);
        depth_d  = depth_q;
        if (load) begin
            depth_d = DEPTH_W'(1);
        end else if (step) begin
            if (match) begin
                depth_d = '0;
            end else if (opens && !overflow) begin
                depth_d = depth_q + DEPTH_W'(1);
            end else if (closes) begin
                depth_d = depth_q - DEPTH_W'(1);
            end
        end
    end

    // Depth register.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/bf_fetch.sv
// Instruction fetch and sequencing: owns pc and state, resolves [ and ] by bracket scans,
// and hands every other opcode to the executor over a valid/ready handshake.
module bf_fetch
    import bf_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DEPTH_W = DEPTH_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_code,
    input  logic              rom_overrun,
    input  logic              cell_zero,
    output logic              ins_valid,
    output logic [2:0]        ins_code,
    input  logic              ins_ready,
    output logic              halted,
    output logic              scan_error
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              err_q;
    logic              err_d;

    scan_dir_t         scan_dir;
    logic              scan_load;
    logic              scan_step;
    logic              scan_match;
    logic              scan_overflow;
    logic              pc_at_zero;

    assign pc_at_zero = (pc_q == '0);
    assign rom_addr   = pc_q;
    assign halted     = (state_q == StHalt);
    assign scan_error = err_q;

    bf_bracket_scan #(
        .DEPTH_W (DEPTH_W)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .dir      (scan_dir),
        .code     (rom_code),
        .load     (scan_load),
        .step     (scan_step),
        .match    (scan_match),
        .overflow (scan_overflow)
    );

    // Next-state, pc update, scan control and executor handshake.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        err_d     = err_q;
        scan_dir  = ScanFwd;
        scan_load = 1'b0;
        scan_step = 1'b0;
        ins_valid = 1'b0;
        ins_code  = OpNop;

        unique case (state_q)
            StFetch: begin
                if (rom_overrun) begin
                    state_d = StHalt;
                end else if (!is_bracket(rom_code)) begin
                    ins_valid = 1'b1;
                    ins_code  = rom_code;
                    if (ins_ready) begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end else if (rom_code == OpIf) begin
                    pc_d = pc_q + ADDR_W'(1);
                    if (cell_zero) begin
                        scan_load = 1'b1;
                        state_d   = StScanFwd;
                    end
                end else begin
                    // A ] at address 0 can never have a matching [.
                    if (pc_at_zero) begin
                        err_d   = 1'b1;
                        state_d = StHalt;
                    end else if (cell_zero) begin
                        pc_d = pc_q + ADDR_W'(1);
                    end else begin
                        scan_load = 1'b1;
                        scan_dir  = ScanBack;
                        pc_d      = pc_q - ADDR_W'(1);
                        state_d   = StScanBack;
                    end
                end
            end

            StScanFwd: begin
                scan_dir = ScanFwd;
                if (rom_overrun) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end else begin
                    scan_step = 1'b1;
                    if (scan_overflow) begin
                        err_d   = 1'b1;
                        state_d = StHalt;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                        if (scan_match) begin
                            state_d = StFetch;
                        end
                    end
                end
            end

            StScanBack: begin
                scan_dir  = ScanBack;
                scan_step = 1'b1;
                if (scan_overflow) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end else if (scan_match) begin
                    // Resume after the [, which is not re-evaluated.
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = StFetch;
                end else if (pc_at_zero) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end else begin
                    pc_d = pc_q - ADDR_W'(1);
                end
            end

            StHalt: begin
                state_d = StHalt;
            end
        endcase

        if (rst) begin
            ins_valid = 1'b0;
        end
    end

    // State, pc and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

endmodule
